control_microsequencer: RTL and testbench
=========================================

Name: control_microsequencer

Overview:
- Parametrised successor to the control-section branch logic.
- Owns the control store address register (CSAR) and evaluates a widened microbranch condition field against the PSR flags and IR[13].
- Adds microsubroutine call/return through an internal return-address stack.
- Sits between the microinstruction register and the control store; its CSAR output drives the control store read address directly.

Parameters:
- CSA_W, 11, control store address width (2048 microwords)
- COND_W, 4, width of the microinstruction condition field (minimum 4)
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_ADDR, 0, CSAR value after reset
- TRAP_ADDR, 2047, microtrap entry address (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold CSAR and stack this cycle
- cond  in  COND_W  condition field of the current microword
- jump_addr  in  CSA_W  JUMP ADDR field of the current microword
- dec_addr  in  CSA_W  decode address formed from IR opcode bits
- ir13  in  1  IR bit 13
- psr  in  4  flags {n,z,v,c}
- csa  out  CSA_W  current control store address (registered)
- sel  out  2  source chosen this cycle: 00 Next, 01 Jump, 10 Dec, 11 Return
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy
- stk_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - csa←RESET_ADDR, sp←0, stk_err←0.
  - Stack contents are don't-care.
  - Reset overrides stall and any in-progress call/return.
- Cond decode (combinational, from cond/psr/ir13):
  - 0 Next; 1 Jump if n; 2 Jump if z; 3 Jump if v; 4 Jump if c; 5 Jump if ir13; 6 Jump; 7 Dec.
  - 8 Jump if !n; 9 Jump if !z; 10 Jump if !v; 11 Jump if !c.
  - 12 Call: Jump and push csa+1.
  - 13 Return: pop.
  - 14, 15 reserved: treated as Next.
- Next address:
  - Next = csa+1, modulo 2^CSA_W (2047+1 wraps to 0).
  - Jump = jump_addr; Dec = dec_addr; Return = stack top.
- Clocking:
  - When !stall, CSAR loads the selected next address at each clk edge.
  - Latency: one cycle from cond valid to new csa.
  - When stall=1: csa, sp, stack and stk_err hold; sel still reflects the current decode.
- Call:
  - sp<STACK_DEPTH: stack[sp]←csa+1, sp←sp+1.
  - sp==STACK_DEPTH (overflow): no push, sp unchanged, stk_err←1, csa←jump_addr.
- Return:
  - sp>0: csa←stack[sp-1], sp←sp-1, sel=11.
  - sp==0 (underflow): sel=00, csa←csa+1, stk_err←1.
- stk_err is sticky; it clears only on reset.
- Only one stack operation per cycle is possible (cond is one-hot in effect), so no simultaneous push/pop case exists.

Optional Feature:
- Macro: USEQ_STACK_TRAP_EN.
- Defined: a call overflow or return underflow forces csa←TRAP_ADDR and sel=01 instead of the default target. stk_err is still set and sp still unchanged.
- Undefined: the default behaviour above applies, and TRAP_ADDR is unused.

Decomposition:
- Package control_pkg holds:
  - the sel encodings (SEL_NEXT, SEL_JUMP, SEL_DEC, SEL_RET);
  - the 4-bit COND_* constants for codes 0–15.
- One natural sub-module: useq_return_stack.
  - Ports: clk, rst, push, pop, din, dout, sp, ovf, unf.
  - Parametrised by STACK_DEPTH and CSA_W.
- Condition decode and CSAR stay in the top module.

Test Plan:
- Reset then cond=0 for 3 cycles → csa 0,1,2,3; sel=00; then csa=2047 with cond=0 → csa wraps to 0.
- csa=5, cond=2, psr=4'b0100, jump_addr=100 → csa=100 next cycle, sel=01; same with psr=0 → csa=6. Repeat with cond=9 and check the inverted result.
- cond=7, dec_addr=1280 → sel=10, csa=1280; cond=5, ir13=1, jump_addr=300 → csa=300.
- Nested calls:
  - At csa=10, cond=12, jump_addr=200 → csa=200, sp=1.
  - At 200, cond=12, jump_addr=400 → csa=400, sp=2.
  - Two cond=13 → csa=201, then 11; sp=0; stk_err=0.
- Error cases:
  - Five calls with STACK_DEPTH=4 → sp=4, stk_err=1, fifth call still jumps (or goes to TRAP_ADDR with USEQ_STACK_TRAP_EN).
  - Return at sp=0 → stk_err=1, csa+1 (or TRAP_ADDR with the macro).
- stall=1 during a call → csa and sp unchanged; rst asserted together with stall and cond=12 → csa=RESET_ADDR, sp=0, stk_err=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the control microsequencer: next-address source selects
// and the microword condition-field codes.
package control_pkg;

    typedef enum logic [1:0] {
        SEL_NEXT = 2'b00,
        SEL_JUMP = 2'b01,
        SEL_DEC  = 2'b10,
        SEL_RET  = 2'b11
    } sel_t;

    localparam logic [3:0] COND_NEXT  = 4'd0;
    localparam logic [3:0] COND_JN    = 4'd1;
    localparam logic [3:0] COND_JZ    = 4'd2;
    localparam logic [3:0] COND_JV    = 4'd3;
    localparam logic [3:0] COND_JC    = 4'd4;
    localparam logic [3:0] COND_JIR13 = 4'd5;
    localparam logic [3:0] COND_JUMP  = 4'd6;
    localparam logic [3:0] COND_DEC   = 4'd7;
    localparam logic [3:0] COND_JNN   = 4'd8;
    localparam logic [3:0] COND_JNZ   = 4'd9;
    localparam logic [3:0] COND_JNV   = 4'd10;
    localparam logic [3:0] COND_JNC   = 4'd11;
    localparam logic [3:0] COND_CALL  = 4'd12;
    localparam logic [3:0] COND_RET   = 4'd13;
    localparam logic [3:0] COND_RSV14 = 4'd14;
    localparam logic [3:0] COND_RSV15 = 4'd15;

endpackage

// File: rtl/useq_return_stack.sv
// Microsubroutine return-address stack. Pushes beyond capacity and pops of an
// empty stack are ignored and reported on ovf/unf.
module useq_return_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int CSA_W       = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [CSA_W-1:0]               din,
    output logic [CSA_W-1:0]               dout,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           ovf,
    output logic                           unf
);
    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int SP_W = AW + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [CSA_W-1:0] mem [STACK_DEPTH];
    logic             full;
    logic             empty;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = AW'(sp - SP_W'(1));
    assign dout   = mem[rd_idx];
    assign ovf    = push && full;
    assign unf    = pop && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Stack contents carry no reset; only the occupancy pointer is control.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/control_microsequencer.sv
// Control store address sequencer: condition decode, CSAR and microsubroutine
// call/return. Optional macro USEQ_STACK_TRAP_EN redirects stack errors to TRAP_ADDR.
module control_microsequencer
    import control_pkg::*;
#(
    parameter int               CSA_W       = 11,
    parameter int               COND_W      = 4,
    parameter int               STACK_DEPTH = 4,
    parameter logic [CSA_W-1:0] RESET_ADDR  = '0,
    parameter logic [CSA_W-1:0] TRAP_ADDR   = CSA_W'(2047)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [COND_W-1:0]            cond,
    input  logic [CSA_W-1:0]             jump_addr,
    input  logic [CSA_W-1:0]             dec_addr,
    input  logic                         ir13,
    input  logic [3:0]                   psr,
    output logic [CSA_W-1:0]             csa,
    output logic [1:0]                   sel,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         stk_err
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic             flag_n, flag_z, flag_v, flag_c;
    logic             cond_legal;
    logic             take;
    logic             push_req, pop_req;
    logic             stk_full, stk_empty;
    logic             ovf, unf;
    logic [CSA_W-1:0] csa_inc;
    logic [CSA_W-1:0] nxt;
    logic [CSA_W-1:0] stk_top;
    sel_t             sel_d;

    assign {flag_n, flag_z, flag_v, flag_c} = psr;
    assign csa_inc    = csa + CSA_W'(1);
    assign stk_full   = (sp == SP_FULL);
    assign stk_empty  = (sp == '0);
    // Codes above 15 in a widened field are reserved and behave as Next.
    assign cond_legal = ((cond >> 4) == '0);

    always_comb begin
        sel_d    = SEL_NEXT;
        nxt      = csa_inc;
        take     = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        if (cond_legal) begin
            case (cond[3:0])
                COND_JN:    take = flag_n;
                COND_JZ:    take = flag_z;
                COND_JV:    take = flag_v;
                COND_JC:    take = flag_c;
                COND_JIR13: take = ir13;
                COND_JUMP:  take = 1'b1;
                COND_JNN:   take = !flag_n;
                COND_JNZ:   take = !flag_z;
                COND_JNV:   take = !flag_v;
                COND_JNC:   take = !flag_c;
                COND_DEC: begin
                    sel_d = SEL_DEC;
                    nxt   = dec_addr;
                end
                COND_CALL: begin
                    take     = 1'b1;
                    push_req = 1'b1;
                end
                COND_RET: begin
                    pop_req = 1'b1;
                    if (!stk_empty) begin
                        sel_d = SEL_RET;
                        nxt   = stk_top;
                    end
                end
                default: ;
            endcase
        end
        if (take) begin
            sel_d = SEL_JUMP;
            nxt   = jump_addr;
        end
`ifdef USEQ_STACK_TRAP_EN
        if ((push_req && stk_full) || (pop_req && stk_empty)) begin
            sel_d = SEL_JUMP;
            nxt   = TRAP_ADDR;
        end
`endif
    end

`ifndef USEQ_STACK_TRAP_EN
    logic [CSA_W-1:0] unused_trap_addr;
    assign unused_trap_addr = TRAP_ADDR;
`endif

    assign sel = sel_d;

    useq_return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .CSA_W       (CSA_W)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push_req && !stall),
        .pop  (pop_req && !stall),
        .din  (csa_inc),
        .dout (stk_top),
        .sp   (sp),
        .ovf  (ovf),
        .unf  (unf)
    );

    // CSAR and sticky stack error register
    always_ff @(posedge clk) begin
        if (rst) begin
            csa     <= RESET_ADDR;
            stk_err <= 1'b0;
        end else if (!stall) begin
            csa <= nxt;
            if (ovf || unf) begin
                stk_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_microsequencer.sv
// Scoreboard bench for control_microsequencer: directed sequences then random
// cycles, checked against a queue-based behavioural model.
module tb_control_microsequencer;
    localparam int CSA_W = 11;
    localparam int COND_W = 4;
    localparam int DEPTH = 4;
    localparam int AMOD = 2048;
    localparam int TRAP = 2047;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [COND_W-1:0] cond;
    logic [CSA_W-1:0]  jump_addr;
    logic [CSA_W-1:0]  dec_addr;
    logic              ir13;
    logic [3:0]        psr;
    logic [CSA_W-1:0]  csa;
    logic [1:0]        sel;
    logic [2:0]        sp;
    logic              stk_err;

    control_microsequencer #(
        .CSA_W(CSA_W), .COND_W(COND_W), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .cond(cond),
        .jump_addr(jump_addr), .dec_addr(dec_addr), .ir13(ir13), .psr(psr),
        .csa(csa), .sel(sel), .sp(sp), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int csa;
        int sp;
        int err;
        int sel;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   m_csa;
    int   m_stk[$];
    int   m_err;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every cycle the DUT presents state + combinational sel.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("csa", int'(csa), mon_e.csa);
            chk("sp", int'(sp), mon_e.sp);
            chk("stk_err", int'(stk_err), mon_e.err);
            chk("sel", int'(sel), mon_e.sel);
        end
    end

    task automatic step(input bit r, input bit s, input int c, input int ja,
                        input int da, input bit i13, input logic [3:0] p);
        exp_t e;
        int   inc, nxt, sl;
        bit   take, do_push, do_pop, err_ev;
        @(posedge clk);
        #1;
        rst = r; stall = s; cond = 4'(c);
        jump_addr = 11'(ja); dec_addr = 11'(da); ir13 = i13; psr = p;

        e.csa = m_csa; e.sp = m_stk.size(); e.err = m_err;
        inc = (m_csa + 1) % AMOD;
        nxt = inc; sl = 0; take = 0; do_push = 0; do_pop = 0; err_ev = 0;
        case (c)
            1: take = p[3];
            2: take = p[2];
            3: take = p[1];
            4: take = p[0];
            5: take = i13;
            6: take = 1;
            7: begin sl = 2; nxt = da; end
            8: take = !p[3];
            9: take = !p[2];
            10: take = !p[1];
            11: take = !p[0];
            12: begin
                take = 1;
                if (m_stk.size() == DEPTH) err_ev = 1;
                else do_push = 1;
            end
            13: begin
                if (m_stk.size() > 0) begin
                    sl = 3; nxt = m_stk[m_stk.size()-1]; do_pop = 1;
                end else err_ev = 1;
            end
            default: ;
        endcase
        if (take) begin sl = 1; nxt = ja; end
`ifdef USEQ_STACK_TRAP_EN
        if (err_ev) begin sl = 1; nxt = TRAP; end
`endif
        e.sel = sl;
        q.push_back(e);

        if (r) begin
            m_csa = 0; m_stk.delete(); m_err = 0;
        end else if (!s) begin
            m_csa = nxt;
            if (do_push) m_stk.push_back(inc);
            if (do_pop) void'(m_stk.pop_back());
            if (err_ev) m_err = 1;
        end
    endtask

    task automatic go(input int c, input int ja);
        step(0, 0, c, ja, 0, 0, 4'b0000);
    endtask

    initial begin
        rst = 1; stall = 0; cond = 0; jump_addr = 0; dec_addr = 0; ir13 = 0; psr = 0;
        repeat (2) @(posedge clk);
        m_csa = 0; m_err = 0; m_stk.delete();

        // sequential flow and address wrap
        step(1, 0, 0, 0, 0, 0, 4'b0000);
        repeat (3) go(0, 0);
        go(6, 2047);
        go(0, 0);
        go(0, 0);

        // conditional jumps on z, direct and inverted
        go(6, 5);
        step(0, 0, 2, 100, 0, 0, 4'b0100);
        go(6, 5);
        step(0, 0, 2, 100, 0, 0, 4'b0000);
        go(6, 5);
        step(0, 0, 9, 100, 0, 0, 4'b0100);
        go(6, 5);
        step(0, 0, 9, 100, 0, 0, 4'b0000);

        // decode and IR13 branch
        step(0, 0, 7, 0, 1280, 0, 4'b0000);
        step(0, 0, 5, 300, 0, 1, 4'b0000);
        step(0, 0, 5, 300, 0, 0, 4'b0000);

        // nested call / return
        go(6, 10);
        go(12, 200);
        go(12, 400);
        go(13, 0);
        go(13, 0);
        go(0, 0);

        // overflow: five calls into a four-deep stack
        for (int k = 0; k < 5; k++) go(12, 50 + 10 * k);
        go(0, 0);
        for (int k = 0; k < 4; k++) go(13, 0);
        go(0, 0);

        // underflow from a clean state
        step(1, 0, 0, 0, 0, 0, 4'b0000);
        go(6, 700);
        go(13, 0);
        go(0, 0);

        // stall during a call, then reset beating stall + call
        step(1, 0, 0, 0, 0, 0, 4'b0000);
        go(12, 20);
        step(0, 1, 12, 900, 0, 0, 4'b0000);
        step(0, 1, 12, 900, 0, 0, 4'b0000);
        go(0, 0);
        for (int k = 0; k < 5; k++) go(12, 30);
        step(1, 1, 12, 900, 0, 0, 4'b0000);
        go(0, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
